// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the bus widths, the NOP word, the reset vector and the fetch state enum.
package fetch_stage_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned AddrWidth  = 32;

  localparam logic [InstrWidth-1:0] NopWord        = 32'h0000_0000;
  localparam logic [AddrWidth-1:0]  DefaultResetPc = 32'h0000_0000;

  typedef enum logic {
    StIdle,
    StRun
  } fetch_state_e;

  // Clear the byte-offset bits of an address.
  function automatic logic [AddrWidth-1:0] word_align(input logic [AddrWidth-1:0] addr);
    return addr & ~AddrWidth'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// PC register, next-PC priority mux and the IDLE/RUN fetch state.
// FETCH_ALIGN_CHECK_EN keeps pc[1:0] as loaded instead of forcing it to zero.
module fetch_stage_pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [AddrWidth-1:0] ResetPc = DefaultResetPc
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [AddrWidth-1:0] flush_pc_i,
  input  logic                 branch_flag_i,
  input  logic [AddrWidth-1:0] branch_target_i,
  output logic                 run_o,
  output logic [AddrWidth-1:0] pc_o
);

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;

  function automatic logic [AddrWidth-1:0] load_value(input logic [AddrWidth-1:0] addr);
`ifdef FETCH_ALIGN_CHECK_EN
    return addr;
`else
    return word_align(addr);
`endif
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving RUN only happens through reset, which the register handles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (state_q == StRun) begin
      if (flush_i) begin
        pc_d = load_value(flush_pc_i);
      end else if (!stall_i) begin
        if (branch_flag_i) begin
          pc_d = load_value(branch_target_i);
        end else begin
          pc_d = pc_q + AddrWidth'(4);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    run_o = (state_q == StRun);
    pc_o  = pc_q;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC/ROM addressing plus the IF/ID pipeline register.
// Optional FETCH_ALIGN_CHECK_EN adds id_address_error and bubbles misaligned fetches.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [AddrWidth-1:0]  RESET_PC = DefaultResetPc,
  parameter logic [InstrWidth-1:0] NOP_WORD = NopWord
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [AddrWidth-1:0]  flush_pc,
  input  logic                  branch_flag,
  input  logic [AddrWidth-1:0]  branch_target,
  output logic                  rom_enable,
  output logic [AddrWidth-1:0]  rom_address,
  input  logic [InstrWidth-1:0] rom_data,
  output logic [AddrWidth-1:0]  id_pc,
  output logic [InstrWidth-1:0] id_instruction,
  output logic                  id_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  id_address_error
`endif
);

  logic                  run;
  logic [AddrWidth-1:0]  pc;

  logic [AddrWidth-1:0]  id_pc_q, id_pc_d;
  logic [InstrWidth-1:0] id_instr_q, id_instr_d;
  logic                  id_valid_q, id_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                  id_err_q, id_err_d;
`endif

  fetch_stage_pc_register #(
    .ResetPc(RESET_PC)
  ) u_pc_register (
    .clk_i          (clock),
    .reset_i        (reset),
    .stall_i        (stall),
    .flush_i        (flush),
    .flush_pc_i     (flush_pc),
    .branch_flag_i  (branch_flag),
    .branch_target_i(branch_target),
    .run_o          (run),
    .pc_o           (pc)
  );

  // A taken branch still captures the current word: it is the delay slot.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    id_err_d   = id_err_q;
`endif
    if (run) begin
      if (flush) begin
        id_pc_d    = '0;
        id_instr_d = NOP_WORD;
        id_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        id_err_d   = 1'b0;
`endif
      end else if (!stall) begin
        id_pc_d    = pc;
        id_instr_d = rom_data;
        id_valid_d = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        id_err_d   = 1'b0;
        if (pc[1:0] != 2'b00) begin
          id_instr_d = NOP_WORD;
          id_valid_d = 1'b0;
          id_err_d   = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      id_pc_q    <= '0;
      id_instr_q <= NOP_WORD;
      id_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      id_err_q   <= 1'b0;
`endif
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      id_err_q   <= id_err_d;
`endif
    end
  end

  always_comb begin
    rom_enable     = run;
    rom_address    = pc;
    id_pc          = id_pc_q;
    id_instruction = id_instr_q;
    id_valid       = id_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    id_address_error = id_err_q;
`endif
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline inside sopc.
- Owns the PC and drives the instruction ROM address; latches the returned word into the IF/ID pipeline register.
- Applies jump/branch redirects from ID with MIPS delay-slot semantics; applies stall holds and exception flushes from control.

Parameters:
- RESET_PC, 32'h00000000, PC value held during reset and fetched first after reset.
- NOP_WORD, 32'h00000000, instruction word injected into ID on flush and at reset.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from control: hold PC and IF/ID contents.
- flush  input  1  from control: exception flush.
- flush_pc  input  32  handler address used with flush.
- branch_flag  input  1  from ID: jump/branch taken.
- branch_target  input  32  redirect address from ID.
- rom_enable  output  1  ROM read enable.
- rom_address  output  32  current PC.
- rom_data  input  32  ROM word; combinational read of rom_address.
- id_pc  output  32  PC of the instruction presented to ID.
- id_instruction  output  32  instruction presented to ID.
- id_valid  output  1  id_instruction is a real fetch, not a bubble.

Behaviour:
- Reset values: pc = RESET_PC, rom_enable = 0, id_pc = 0, id_instruction = NOP_WORD, id_valid = 0.
- State machine, two states:
  - IDLE: entered on reset; rom_enable = 0.
  - RUN: rom_enable = 1.
  - IDLE -> RUN on the first edge with reset low.
  - RUN -> IDLE only on reset.
  - No fetch is issued in IDLE.
- In RUN, each edge applies the first matching case in this priority order:
  1. reset
  2. flush: pc <= flush_pc; id_instruction <= NOP_WORD; id_valid <= 0; id_pc <= 0.
  3. stall: pc and all id_* outputs hold.
  4. branch_flag: pc <= branch_target; IF/ID captures the current rom_data/pc normally. That word is the delay slot and is not squashed.
  5. Default: pc <= pc + 4; IF/ID captures rom_data and pc, with id_valid <= 1.
- branch_flag is ignored while stall is high. ID holds its registers, so it re-asserts branch_flag once the stall is released.
- The first edge after reset deasserts (IDLE -> RUN) does not advance the PC. The fetch at RESET_PC reaches ID one cycle later.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 32'h00000000. No flag is raised.
- Without the optional feature, pc[1:0] is forced to 0 on every load. Misaligned targets are silently aligned.
- Reset asserted mid-stall or mid-flush wins unconditionally. The next cycle shows the full reset values above.
- Latency:
  - ROM read is combinational in the same cycle.
  - IF -> ID latency is 1 cycle.
  - Redirect penalty is 0 bubbles; the delay slot occupies the slot.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output id_address_error (1 bit), reset to 0.
  - pc[1:0] is kept as loaded and not forced to 0.
  - When pc[1:0] != 0, the IF/ID capture sets id_instruction = NOP_WORD, id_valid = 0 and id_address_error = 1.
  - PC still advances by 4 (control is expected to flush).
  - id_address_error clears on the next non-stalled capture.
- When undefined: no port is added, and the alignment behaviour is as described in Behaviour.

Decomposition:
- Shared package holds:
  - instruction width constant (32) and address width constant (32).
  - NOP word constant.
  - default reset-vector constant.
  - fetch state enum (IDLE, RUN).
- One natural sub-module: pc_register. It contains the PC register, next-PC priority mux and the IDLE/RUN state. fetch_stage wraps it together with the IF/ID register.

Test Plan:
- Reset then release, ROM word at 0x0 = 32'h34010000: rom_enable rises 1 edge after release; rom_address sequence 0x0, 0x4, 0x8; id_pc = 0x0 and id_instruction = 32'h34010000 one cycle after first fetch.
- branch_flag = 1 with branch_target = 0x20 while fetching 0x8: id_pc shows 0x8 (delay slot, id_valid = 1), then 0x20; 0xC never appears at ID.
- stall held high for 3 cycles at pc = 0x10, with branch_flag pulsed during the stall: rom_address stays 0x10 and id_* stays frozen for 3 cycles; then 0x14 resumes; the branch is ignored.
- flush with flush_pc = 0x180 while stall = 1 and branch_flag = 1: next rom_address = 0x180, id_instruction = 0, id_valid = 0.
- Force PC to 0xFFFFFFFC via flush_pc = 0xFFFFFFFC: next rom_address = 0x00000000.
- With FETCH_ALIGN_CHECK_EN, branch_target = 0x22: the capture at 0x22 gives id_address_error = 1, id_valid = 0, id_instruction = 0. Without the macro, rom_address shows 0x20.
